rf_wb_arbiter: RTL

Write-port arbiter and sequencer for the 32x32 register file in the dynamic pipeline. Several writeback sources (ALU, multiplier, load/store unit) share the single regfile write port (wena/waddr/wdata). The block grants one source per cycle by round-robin, registers the winning write onto the port, and drops writes to r0. An optional busy-bit scoreboard flags registers with outstanding writes so issue logic can stall.

---
 rtl/rf_wb_arbiter_pkg.sv | 11 +
 rtl/rf_wb_arbiter_rr_pick.sv | 22 ++
 rtl/rf_wb_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared levels and helpers for the regfile writeback arbiter.
package rf_wb_arbiter_pkg;
    localparam logic RST_N_ACTIVE = 1'b0;
    localparam logic WENA_ACTIVE  = 1'b1;
    localparam int   REG_ZERO     = 0;

    // True when more than one bit is set; requester vectors are at most 8 wide.
    function automatic logic multi_hot(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; search starts at ptr+1 and wraps.
// Produces a one-hot grant, or zero when nothing is valid.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);
    logic [PW:0]  sh;
    logic [N-1:0] rot;
    logic [N-1:0] low;

    // Rotate so the highest-priority source lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        sh    = {1'b0, ptr} + 1'b1;
        rot   = N'({valid, valid} >> sh);
        low   = rot & (~rot + 1'b1);
        grant = N'(({low, low} << sh) >> N);
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin sharing of the single regfile write port, r0 writes dropped.
// Optional busy-bit scoreboard for issue stalls is enabled by WB_SCOREBOARD_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      rf_wena,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [IW-1:0]             grant_id,
    output logic [CNT_W-1:0]          conflict_cnt,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd,
    input  logic [ADDR_W-1:0]         chk_addr1,
    input  logic [ADDR_W-1:0]         chk_addr2,
    output logic                      chk_busy1,
    output logic                      chk_busy2
);
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]      gidx;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [IW-1:0]      ptr_q, ptr_d, grant_id_q, grant_id_d;
    logic               rf_wena_q, rf_wena_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) gidx = IW'(i);
        req_ready  = (rst == RST_N_ACTIVE) ? '0 : pick;
        xfer       = |(req_valid & req_ready);
        sel_addr   = req_waddr[gidx*ADDR_W +: ADDR_W];
        ptr_d      = xfer ? gidx : ptr_q;
        // An r0 write still consumes its grant; only the enable is suppressed.
        rf_wena_d  = (xfer && sel_addr != ADDR_W'(REG_ZERO)) ? WENA_ACTIVE : ~WENA_ACTIVE;
        rf_waddr_d = xfer ? sel_addr : rf_waddr_q;
        rf_wdata_d = xfer ? req_wdata[gidx*DATA_W +: DATA_W] : rf_wdata_q;
        grant_id_d = xfer ? gidx : grant_id_q;
        cnt_d      = (multi_hot(8'(req_valid)) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_N_ACTIVE) begin
            ptr_q      <= IW'(NUM_REQ - 1);
            rf_wena_q  <= ~WENA_ACTIVE;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_wena_q  <= rf_wena_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rf_wena      = rf_wena_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign grant_id     = grant_id_q;
    assign conflict_cnt = cnt_q;

`ifdef WB_SCOREBOARD_EN
    localparam int NR = 1 << ADDR_W;
    logic [NR-1:0] pend_q, pend_d;

    // Set after clear so an issue landing on a committing register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (rf_wena_q == WENA_ACTIVE) pend_d[rf_waddr_q] = 1'b0;
        if (issue_valid && issue_rd != ADDR_W'(REG_ZERO)) pend_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_N_ACTIVE) pend_q <= '0;
        else pend_q <= pend_d;
    end

    // The committing write is forwarded by the regfile, so it does not count as busy.
    assign chk_busy1 = (chk_addr1 != ADDR_W'(REG_ZERO)) && pend_q[chk_addr1] &&
                       !(rf_wena_q == WENA_ACTIVE && rf_waddr_q == chk_addr1);
    assign chk_busy2 = (chk_addr2 != ADDR_W'(REG_ZERO)) && pend_q[chk_addr2] &&
                       !(rf_wena_q == WENA_ACTIVE && rf_waddr_q == chk_addr2);
`else
    logic sb_unused;
    assign sb_unused = ^{issue_valid, issue_rd, chk_addr1, chk_addr2};
    assign chk_busy1 = 1'b0;
    assign chk_busy2 = 1'b0;
`endif
endmodule
